// File: rtl/regfile_wb_scheduler_pkg.sv
// rtl/regfile_wb_scheduler_pkg.sv - shared widths and requester indices for the writeback scheduler
package regfile_wb_scheduler_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int NUM_REQ        = 2;

    localparam int REQ_ALU = 0;
    localparam int REQ_MC  = 1;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - writeback request bus between the result sources and the scheduler
interface regfile_wb_scheduler_if
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_reg, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_reg, input  req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// rtl/regfile_wb_scheduler_rr_arbiter2.sv - two-way round-robin arbiter with last-winner pointer
module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    // Index of the most recent winner; the other requester wins the next conflict.
    logic last_grant;

    always_comb begin
        grant          = '0;
        grant[REQ_ALU] = req[REQ_ALU] & (~req[REQ_MC]  |  last_grant);
        grant[REQ_MC]  = req[REQ_MC]  & (~req[REQ_ALU] | ~last_grant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[REQ_MC];
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - shares the register file write port between two writeback sources
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_wb_scheduler_if.slave    wb,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_reg,
    output logic                     rf_write,
    output logic [ADDR_W-1:0]        rf_write_reg,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic [(1<<ADDR_W)-1:0]   busy
);

    logic [NUM_REQ-1:0]     grant;
    logic                   xfer;
    logic [ADDR_W-1:0]      win_reg;
    logic [DATA_W-1:0]      win_data;
    logic [(1<<ADDR_W)-1:0] busy_next;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wb.req_valid),
        .grant (grant)
    );

    assign wb.req_ready = grant;
    assign xfer         = |grant;

    always_comb begin
        win_reg  = wb.req_reg[REQ_ALU*ADDR_W +: ADDR_W];
        win_data = wb.req_data[REQ_ALU*DATA_W +: DATA_W];
        if (grant[REQ_MC]) begin
            win_reg  = wb.req_reg[REQ_MC*ADDR_W +: ADDR_W];
            win_data = wb.req_data[REQ_MC*DATA_W +: DATA_W];
        end
    end

    // Writes to $0 still complete the handshake but never reach the file.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write      <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else if (xfer) begin
            rf_write      <= (win_reg != '0);
            rf_write_reg  <= win_reg;
            rf_write_data <= win_data;
        end else begin
            rf_write      <= 1'b0;
        end
    end

    // Set after clear: a fresh reservation outlives the commit of the old producer.
    always_comb begin
        busy_next = busy;
        if (rf_write) begin
            busy_next[rf_write_reg] = 1'b0;
        end
        if (rsv_valid && (rsv_reg != '0)) begin
            busy_next[rsv_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for the writeback scheduler
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  vld;
    logic [4:0]  r0, r1, rr;
    logic [31:0] d0, d1;
    logic        rv;

    logic        rf_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [31:0] busy;

    int n_checks = 0;
    int n_err    = 0;

    regfile_wb_scheduler_if wb ();

    assign wb.req_valid = vld;
    assign wb.req_reg   = {r1, r0};
    assign wb.req_data  = {d1, d0};

    regfile_wb_scheduler dut (
        .clk           (clk),
        .reset         (rst),
        .wb            (wb),
        .rsv_valid     (rv),
        .rsv_reg       (rr),
        .rf_write      (rf_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who won last, what the file port shows, which registers await a write.
    int          m_last;
    bit          m_wr;
    bit [4:0]    m_reg;
    bit [31:0]   m_data;
    bit          m_busy[32];
    bit [1:0]    m_gnt;

    function automatic bit [1:0] model_grant(input bit [1:0] v);
        if (v == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return v;
    endfunction

    function automatic bit [31:0] model_busy();
        bit [31:0] b = '0;
        for (int n = 0; n < 32; n++) b[n] = m_busy[n];
        return b;
    endfunction

    task automatic model_step();
        bit [1:0] g;
        g = model_grant(vld);
        m_gnt = 2'b00;
        if (rst) begin
            m_wr = 0; m_reg = 0; m_data = 0; m_last = 1;
            for (int n = 0; n < 32; n++) m_busy[n] = 0;
        end else begin
            if (m_wr) m_busy[m_reg] = 0;
            if (rv && rr != 0) m_busy[rr] = 1;
            m_gnt = g;
            if (g != 2'b00) begin
                m_last = g[1] ? 1 : 0;
                m_reg  = g[1] ? r1 : r0;
                m_data = g[1] ? d1 : d0;
                m_wr   = (m_reg != 0);
            end else begin
                m_wr = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input int cyc);
        if (!rst) check($sformatf("rnd%0d_ready", cyc), 32'(wb.req_ready), 32'(model_grant(vld)));
        check($sformatf("rnd%0d_wr", cyc),   32'(rf_write),     32'(m_wr));
        check($sformatf("rnd%0d_reg", cyc),  32'(rf_write_reg), 32'(m_reg));
        check($sformatf("rnd%0d_data", cyc), rf_write_data,     m_data);
        check($sformatf("rnd%0d_busy", cyc), busy,              model_busy());
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit rst; bit [1:0] vld; bit [4:0] r0; bit [31:0] d0; bit [4:0] r1; bit [31:0] d1;
        bit rv; bit [4:0] rr;
        bit [1:0] e_rdy; bit e_wr; bit [4:0] e_reg; bit [31:0] e_data; bit [31:0] e_busy;
    } vec_t;
    vec_t vecs[$];

    task automatic addv(input bit a_rst, input bit [1:0] a_vld, input bit [4:0] a_r0, input bit [31:0] a_d0,
                        input bit [4:0] a_r1, input bit [31:0] a_d1, input bit a_rv, input bit [4:0] a_rr,
                        input bit [1:0] e_rdy, input bit e_wr, input bit [4:0] e_reg,
                        input bit [31:0] e_data, input bit [31:0] e_busy);
        vec_t v;
        v.rst = a_rst; v.vld = a_vld; v.r0 = a_r0; v.d0 = a_d0; v.r1 = a_r1; v.d1 = a_d1;
        v.rv = a_rv; v.rr = a_rr; v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_reg = e_reg;
        v.e_data = e_data; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit a_rst, input bit [1:0] a_vld, input bit [4:0] a_r0, input bit [31:0] a_d0,
                         input bit [4:0] a_r1, input bit [31:0] a_d1, input bit a_rv, input bit [4:0] a_rr);
        rst = a_rst; vld = a_vld; r0 = a_r0; d0 = a_d0; r1 = a_r1; d1 = a_d1; rv = a_rv; rr = a_rr;
    endtask

    initial begin
        bit       got;
        bit [1:0] cur_vld;

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        m_last = 1;
        repeat (2) advance();

        //    rst vld r0  d0            r1  d1            rv rr   rdy wr reg data          busy
        addv(1, 0, 0,  0,            0,  0,            1, 6,   0, 0, 0,  0,            0);
        for (int i = 0; i < 4; i++)
            addv(0, 0, 0, 0,         0,  0,            0, 0,   0, 0, 0,  0,            0);
        addv(0, 3, 3,  32'hA0000003, 4,  32'hB0000004, 0, 0,   1, 0, 0,  0,            0);
        addv(0, 3, 3,  32'hA0000003, 4,  32'hB0000004, 0, 0,   2, 1, 3,  32'hA0000003, 0);
        addv(0, 3, 3,  32'hA0000003, 4,  32'hB0000004, 0, 0,   1, 1, 4,  32'hB0000004, 0);
        addv(0, 3, 3,  32'hA0000003, 4,  32'hB0000004, 0, 0,   2, 1, 3,  32'hA0000003, 0);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 1, 4,  32'hB0000004, 0);
        addv(0, 1, 7,  32'hDEADBEEF, 0,  0,            0, 0,   1, 0, 4,  32'hB0000004, 0);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 1, 7,  32'hDEADBEEF, 0);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 0, 7,  32'hDEADBEEF, 0);
        addv(0, 0, 0,  0,            0,  0,            1, 9,   0, 0, 7,  32'hDEADBEEF, 0);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 0, 7,  32'hDEADBEEF, 32'h200);
        addv(0, 2, 0,  0,            9,  32'h12345678, 0, 0,   2, 0, 7,  32'hDEADBEEF, 32'h200);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 1, 9,  32'h12345678, 32'h200);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 0, 9,  32'h12345678, 0);
        addv(0, 0, 0,  0,            0,  0,            1, 5,   0, 0, 9,  32'h12345678, 0);
        addv(0, 1, 5,  32'h55555555, 0,  0,            0, 0,   1, 0, 9,  32'h12345678, 32'h20);
        addv(0, 0, 0,  0,            0,  0,            1, 5,   0, 1, 5,  32'h55555555, 32'h20);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 0, 5,  32'h55555555, 32'h20);
        addv(0, 2, 0,  0,            0,  32'h0BADF00D, 1, 0,   2, 0, 5,  32'h55555555, 32'h20);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 0, 0,  32'h0BADF00D, 32'h20);
        addv(0, 1, 5,  32'h00000055, 0,  0,            0, 0,   1, 0, 0,  32'h0BADF00D, 32'h20);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 1, 5,  32'h00000055, 32'h20);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 0, 5,  32'h00000055, 0);
        addv(0, 1, 12, 32'hCAFE0012, 0,  0,            1, 12,  1, 0, 5,  32'h00000055, 0);
        addv(1, 0, 0,  0,            0,  0,            0, 0,   0, 1, 12, 32'hCAFE0012, 32'h1000);
        addv(0, 3, 1,  32'h11111111, 2,  32'h22222222, 0, 0,   1, 0, 0,  0,            0);
        addv(0, 2, 0,  0,            2,  32'h22222222, 0, 0,   2, 1, 1,  32'h11111111, 0);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 1, 2,  32'h22222222, 0);
        addv(0, 0, 0,  0,            0,  0,            0, 0,   0, 0, 2,  32'h22222222, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].r0, vecs[i].d0,
                  vecs[i].r1, vecs[i].d1, vecs[i].rv, vecs[i].rr);
            @(negedge clk);
            if (!vecs[i].rst) check($sformatf("vec%0d_ready", i), 32'(wb.req_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_wr", i),   32'(rf_write),     32'(vecs[i].e_wr));
            check($sformatf("vec%0d_reg", i),  32'(rf_write_reg), 32'(vecs[i].e_reg));
            check($sformatf("vec%0d_data", i), rf_write_data,     vecs[i].e_data);
            check($sformatf("vec%0d_busy", i), busy,              vecs[i].e_busy);
            advance();
        end

        // Starved requester: req 0 keeps issuing new writes, req 1 holds until served.
        got = 0;
        for (int k = 0; k < 2 && !got; k++) begin
            drive(0, 3, 10, 32'hA5A50000 + 32'(k), 11, 32'h0000B11B, 0, 0);
            @(negedge clk);
            check_model(1000 + k);
            if (wb.req_ready[1]) got = 1;
            advance();
        end
        check("mc_grant_within_2", 32'(got), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_model(1002);
        advance();

        // Random traffic; a requester that was not granted keeps its request stable.
        cur_vld = 0;
        for (int c = 0; c < 400; c++) begin
            bit [1:0] nv;
            nv = cur_vld;
            if (!(cur_vld[0] && !m_gnt[0])) begin
                nv[0] = ($urandom_range(0, 3) != 0);
                r0 = 5'($urandom_range(0, 7));
                d0 = $urandom;
            end
            if (!(cur_vld[1] && !m_gnt[1])) begin
                nv[1] = ($urandom_range(0, 3) != 0);
                r1 = 5'($urandom_range(0, 7));
                d1 = $urandom;
            end
            cur_vld = nv;
            vld = nv;
            rst = ($urandom_range(0, 49) == 0);
            rv  = $urandom_range(0, 1) == 1;
            rr  = 5'($urandom_range(0, 7));
            @(negedge clk);
            check_model(c);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler for the 32×32 register file. Shares the file's single synchronous write port between two writeback requesters (req 0: ALU/single-cycle path; req 1: multi-cycle path such as load/mult-div) using round-robin arbitration with valid/ready handshakes. Maintains a per-register pending-write scoreboard for the issue/hazard logic. Sits between the execute/memory writeback sources and the register file's `write`/`write_reg`/`write_data` inputs.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (2**ADDR_W registers)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  2  per-requester write request
- `req_reg`  in  2×ADDR_W  destination register per requester (packed, req 0 in LSBs)
- `req_data`  in  2×DATA_W  write data per requester (packed, req 0 in LSBs)
- `req_ready`  out  2  grant; the transfer completes when `req_valid[i] && req_ready[i]`
- `rsv_valid`  in  1  issue stage reserves a destination register
- `rsv_reg`  in  ADDR_W  register being reserved
- `rf_write`  out  1  to register file `write`
- `rf_write_reg`  out  ADDR_W  to register file `write_reg`
- `rf_write_data`  out  DATA_W  to register file `write_data`
- `busy`  out  2**ADDR_W  scoreboard; bit n = write to register n outstanding

## Operation
- Arbitration:
  - Combinational and one-hot: at most one `req_ready` bit is high per cycle.
  - `req_ready[i]` is high only when `req_valid[i]` is high and i wins.
  - Single requester valid: it wins.
  - Both valid: the requester not granted most recently wins.
- Priority pointer `last_grant`:
  - Updates on every completed transfer.
  - Reset value 1, so req 0 wins the first conflict.
- Output register: on a completed transfer, `rf_write_reg`/`rf_write_data` load the winner's fields.
  - `rf_write` = 1 if `req_reg` ≠ 0, else 0 (writes to $0 are accepted and dropped).
  - No transfer: `rf_write` = 0 and `rf_write_reg`/`rf_write_data` hold their values.
- Scoreboard, per edge:
  - Clear `busy[rf_write_reg]` when `rf_write` = 1, i.e. the write commits into the file this edge.
  - Set `busy[rsv_reg]` when `rsv_valid` = 1 and `rsv_reg` ≠ 0.
  - Same register set and cleared on one edge: set wins, since a new producer is outstanding.
  - `busy[0]` is always 0.
- Requests do not require a prior reservation; a clear on a non-busy register has no effect.
- Reset (synchronous, wins over all other activity, including mid-transfer):
  - `rf_write`=0, `rf_write_reg`=0, `rf_write_data`=0, `busy`=0, `last_grant`=1.
  - `req_ready` (combinational) is ignored during the reset cycle; no transfer is recorded.

## Timing
- Request in cycle t, granted → `rf_write` high during cycle t+1; the register file captures at the end of t+1.
- `busy` bit drops at the end of t+1 and reads 0 in cycle t+2.
- A reservation in cycle t shows `busy`=1 from cycle t+1.
- Throughput: one write per cycle, back-to-back, either requester.
- Loser under contention: must hold `req_valid`/`req_reg`/`req_data` stable until granted.
  - Guaranteed grant within 2 cycles.
- `req_ready` depends combinationally on `req_valid` and `last_grant` only; no dependence on `busy`.

## Structure
- Shared package: `DATA_W`/`ADDR_W` defaults, `NUM_REQ` = 2, and the requester index constants `REQ_ALU` = 0 and `REQ_MC` = 1.
- One natural sub-module: `rr_arbiter2`.
  - Holds the two-way round-robin grant logic and the `last_grant` register.
  - Interface: `clk`, `reset`, `req`[2], `grant`[2].
  - Advance input = any grant taken.
- The scoreboard and output register stay in the top module.

## Test plan
- Reset, then idle → all outputs 0; `busy` = 0 for 5 cycles, including while `rsv_valid` pulses during the reset cycle.
- Req 0 only, reg 7, data 0xDEADBEEF → `req_ready`=01 that cycle; next cycle `rf_write`=1, `rf_write_reg`=7, `rf_write_data`=0xDEADBEEF; following cycle `rf_write`=0.
- Both valid for 4 cycles (req 0 → reg 3, req 1 → reg 4) → grants 01,10,01,10; `rf_write_reg` sequence 3,4,3,4 one cycle later.
- Reserve reg 9, then req 1 writes reg 9 two cycles later → `busy[9]` high from the cycle after the reservation; reads 0 two cycles after the grant.
- Reserve reg 5 in the cycle where `rf_write`=1 to reg 5 → `busy[5]` stays 1.
  - Reserve or write reg 0 → `rf_write`=0, `busy[0]`=0, handshake still completes.
- Assert `reset` in the cycle after a grant → next cycle `rf_write`=0, `busy`=0, and the next conflict is won by req 0.
